// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider bank.
//   div_state_e : per-channel FSM state encoding
//   clamp_div   : maps a requested half-period of 0 onto 1 so that the
//                 terminal compare (cnt >= div-1) can never underflow
// ----------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP    = 2'd0,
    LO      = 2'd1,
    HI      = 2'd2,
    STEP_HI = 2'd3
  } div_state_e;

  // Widest divisor the clamp helper handles; channels cast in and out.
  localparam int MAX_CNT_W = 32;

  function automatic logic [MAX_CNT_W-1:0] clamp_div(input logic [MAX_CNT_W-1:0] val);
    return (val == '0) ? 32'd1 : val;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// ----------------------------------------------------------------------------
// clk_div_channel
// One divider channel: shadow and active half-period, phase counter, FSM,
// registered slow clock and first-high-cycle tick.
//
// Ports
//   clk, rst    : system clock, synchronous active-high reset
//   en          : channel enable
//   mode        : 0 free-run, 1 single-step
//   step        : one-cycle step request (single-step mode)
//   div_wr      : write strobe for this channel's shadow divisor
//   div_val     : new half-period (0 is stored as 1)
//   slow_clk    : divided clock, registered
//   tick        : high only in the first cycle of each high phase
//   state_dbg   : current FSM state
//
// Strobe semantics: step and div_wr are single-cycle strobes sampled on the
// clock edge; there is no backpressure, and a step that arrives while a
// stepped pulse is still high is dropped rather than queued.
// ----------------------------------------------------------------------------
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             step,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_val,
  output logic             slow_clk,
  output logic             tick,
  output logic [1:0]       state_dbg
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_shd_q, div_shd_d;
  logic             slow_q, slow_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] wr_val;
  logic             term;

  assign wr_val = CNT_W'(clamp_div(MAX_CNT_W'(div_val)));

  // Greater-or-equal rather than equality so a corrupted counter still
  // terminates the phase instead of wrapping through the full range.
  assign term = (cnt_q >= (div_act_q - CNT_W'(1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slow_d    = slow_q;
    tick_d    = 1'b0;
    div_act_d = div_act_q;
    div_shd_d = div_wr ? wr_val : div_shd_q;

    case (state_q)
      STOP: begin
        cnt_d  = '0;
        slow_d = 1'b0;
        // While stopped the active divisor tracks the shadow, including a
        // write arriving this very cycle, so the next phase uses it.
        div_act_d = div_wr ? wr_val : div_shd_q;
        if (en && !mode) begin
          state_d = LO;
        end else if (en && mode && step) begin
          state_d = STEP_HI;
          slow_d  = 1'b1;
          tick_d  = 1'b1;
        end
      end

      LO: begin
        // Output is already low, so stopping here cannot leave a runt pulse.
        if (!en || mode) begin
          state_d = STOP;
          cnt_d   = '0;
        end else if (term) begin
          state_d   = HI;
          cnt_d     = '0;
          slow_d    = 1'b1;
          tick_d    = 1'b1;
          div_act_d = div_shd_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HI: begin
        // Enable/mode are only consulted at the end of the high phase.
        if (term) begin
          cnt_d     = '0;
          slow_d    = 1'b0;
          div_act_d = div_shd_q;
          state_d   = (en && !mode) ? LO : STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STEP_HI: begin
        if (term) begin
          state_d = STOP;
          cnt_d   = '0;
          slow_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = STOP;
        cnt_d   = '0;
        slow_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STOP;
      cnt_q     <= '0;
      div_act_q <= CNT_W'(DEFAULT_DIV);
      div_shd_q <= CNT_W'(DEFAULT_DIV);
      slow_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      slow_q    <= slow_d;
      tick_q    <= tick_d;
    end
  end

  assign slow_clk  = slow_q;
  assign tick      = tick_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/clk_div_bank.sv
// ----------------------------------------------------------------------------
// clk_div_bank
// Bank of CHANNELS independent programmable clock dividers. Each channel
// produces a 50 % duty slow clock and a tick on each rising edge, either
// free-running or one period per step request.
//
// Ports
//   clk, rst   : system clock, synchronous active-high reset
//   en         : per-channel enable
//   mode       : per-channel mode, 0 free-run, 1 single-step
//   step       : per-channel one-cycle step request
//   div_wr     : divisor write strobe
//   div_sel    : channel addressed by div_wr (out-of-range ignored)
//   div_val    : new half-period in clk cycles (0 treated as 1)
//   slow_clk   : per-channel divided clock
//   tick       : per-channel first-high-cycle strobe
//   dbg_state  : per-channel FSM state, 2 bits per channel
// ----------------------------------------------------------------------------
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 1_000_000,
  parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   en,
  input  logic [CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]   step,
  input  logic                  div_wr,
  input  logic [SEL_W-1:0]      div_sel,
  input  logic [CNT_W-1:0]      div_val,
  output logic [CHANNELS-1:0]   slow_clk,
  output logic [CHANNELS-1:0]   tick,
  output logic [2*CHANNELS-1:0] dbg_state
);

  logic [CHANNELS-1:0] wr_ch;

  // Only addresses below CHANNELS can match, so out-of-range selects fall
  // through with no strobe raised.
  always_comb begin
    wr_ch = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (div_wr && (div_sel == SEL_W'(i))) begin
        wr_ch[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[g]),
      .mode      (mode[g]),
      .step      (step[g]),
      .div_wr    (wr_ch[g]),
      .div_val   (div_val),
      .slow_clk  (slow_clk[g]),
      .tick      (tick[g]),
      .state_dbg (dbg_state[2*g +: 2])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// ----------------------------------------------------------------------------
// tb_clk_div_bank
// Self-checking bench for clk_div_bank with three channels, DEFAULT_DIV=4.
// A phase-level reference model predicts slow_clk/tick every cycle; directed
// scenarios also measure phase lengths directly.
// ----------------------------------------------------------------------------
module tb_clk_div_bank;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int DD = 4;
  localparam int SW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH-1:0]   en, mode, step;
  logic            div_wr;
  logic [SW-1:0]   div_sel;
  logic [CW-1:0]   div_val;
  logic [CH-1:0]   slow_clk, tick;
  logic [2*CH-1:0] dbg_state;

  clk_div_bank #(
    .CHANNELS    (CH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .step      (step),
    .div_wr    (div_wr),
    .div_sel   (div_sel),
    .div_val   (div_val),
    .slow_clk  (slow_clk),
    .tick      (tick),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2*CH-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase view of a channel: idle, low phase, free-run high phase, or a
  // stepped high phase, with the number of cycles left in that phase.
  localparam int P_IDLE = 0, P_LOW = 1, P_HIGH = 2, P_STEP = 3;
  int m_phase [CH];
  int m_left  [CH];
  int m_shadow[CH];

  task automatic model_step();
    logic [CH-1:0] es, et;
    int nv;
    bit wr;
    es = '0;
    et = '0;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_phase[c]  = P_IDLE;
        m_left[c]   = 0;
        m_shadow[c] = DD;
      end else begin
        wr = div_wr && (int'(div_sel) == c);
        nv = (div_val == 0) ? 1 : int'(div_val);
        case (m_phase[c])
          P_IDLE: begin
            if (en[c] && !mode[c]) begin
              m_phase[c] = P_LOW;
              m_left[c]  = wr ? nv : m_shadow[c];
            end else if (en[c] && mode[c] && step[c]) begin
              m_phase[c] = P_STEP;
              m_left[c]  = wr ? nv : m_shadow[c];
              et[c]      = 1'b1;
            end
          end
          P_LOW: begin
            if (!en[c] || mode[c]) begin
              m_phase[c] = P_IDLE;
            end else begin
              m_left[c]--;
              if (m_left[c] == 0) begin
                m_phase[c] = P_HIGH;
                m_left[c]  = m_shadow[c];
                et[c]      = 1'b1;
              end
            end
          end
          P_HIGH: begin
            m_left[c]--;
            if (m_left[c] == 0) begin
              m_phase[c] = (en[c] && !mode[c]) ? P_LOW : P_IDLE;
              m_left[c]  = m_shadow[c];
            end
          end
          default: begin
            m_left[c]--;
            if (m_left[c] == 0) m_phase[c] = P_IDLE;
          end
        endcase
        if (wr) m_shadow[c] = nv;
      end
      es[c] = (m_phase[c] == P_HIGH) || (m_phase[c] == P_STEP);
    end
    exp_q.push_back({es, et});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    logic [2*CH-1:0] e;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check_eq("outs", 32'({slow_clk, tick}), 32'(e));
  endtask

  task automatic write_div(input int sel, input int val);
    div_wr  = 1'b1;
    div_sel = SW'(sel);
    div_val = CW'(val);
    cyc();
    div_wr  = 1'b0;
  endtask

  // Cycles the current level of slow_clk[ch] persists, current one included.
  task automatic measure(input int ch, input logic lvl, output int n);
    n = 0;
    while (slow_clk[ch] == lvl && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_rise(input int ch, output int n);
    n = 0;
    while (!slow_clk[ch] && n < 40) begin
      cyc();
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, hi, tk;
    rst = 1'b1; en = '0; mode = '0; step = '0;
    div_wr = 1'b0; div_sel = '0; div_val = '0;
    cyc();
    cyc();
    rst = 1'b0;
    check_eq("rst_outs", 32'({slow_clk, tick}), 32'd0);

    // free-run ch0 at the reset divisor
    en[0] = 1'b1;
    wait_rise(0, n);
    check_eq("first_rise", n, 5);
    check_eq("tick_rise", 32'(tick[0]), 32'd1);
    measure(0, 1'b1, n); check_eq("hi_len", n, 4);
    measure(0, 1'b0, n); check_eq("lo_len", n, 4);

    // new divisor written mid-high: current phase keeps its length
    cyc();
    write_div(0, 2);
    measure(0, 1'b1, n); check_eq("hi_finish", n, 2);
    measure(0, 1'b0, n); check_eq("lo_new", n, 2);
    measure(0, 1'b1, n); check_eq("hi_new", n, 2);

    // zero divisor behaves as one
    write_div(0, 0);
    repeat (6) cyc();
    wait_rise(0, n);
    measure(0, 1'b1, n); check_eq("d0_hi", n, 1);
    measure(0, 1'b0, n); check_eq("d0_lo", n, 1);

    // single-step ch1 at default divisor
    en[1] = 1'b1; mode[1] = 1'b1;
    cyc();
    step[1] = 1'b1;
    cyc();
    step[1] = 1'b0;
    check_eq("step_rise", 32'({slow_clk[1], tick[1]}), 32'b11);
    hi = 1; tk = 1;
    for (int k = 0; k < 10; k++) begin
      step[1] = (k == 1);
      cyc();
      hi += slow_clk[1];
      tk += tick[1];
    end
    step[1] = 1'b0;
    check_eq("step_hi_len", hi, 4);
    check_eq("step_ticks", tk, 1);
    step[1] = 1'b1;
    cyc();
    step[1] = 1'b0;
    check_eq("step2", 32'(slow_clk[1]), 32'd1);
    repeat (6) cyc();

    // disable during high: full-length high, then quiet
    write_div(0, 4);
    repeat (10) cyc();
    wait_rise(0, n);
    cyc();
    en[0] = 1'b0;
    measure(0, 1'b1, n); check_eq("dis_hi", n, 3);
    hi = 0;
    for (int k = 0; k < 12; k++) begin cyc(); hi += slow_clk[0]; end
    check_eq("dis_stay", hi, 0);

    // disable during low: no pulse
    en[0] = 1'b1;
    cyc(); cyc();
    en[0] = 1'b0;
    hi = 0;
    for (int k = 0; k < 10; k++) begin cyc(); hi += slow_clk[0]; end
    check_eq("dis_lo", hi, 0);

    // reset mid-high with divisor 3 programmed
    en[0] = 1'b1;
    write_div(0, 3);
    wait_rise(0, n);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("rst_mid", 32'({slow_clk, tick}), 32'd0);
    wait_rise(0, n);
    check_eq("rst_rise", n, 5);
    measure(0, 1'b1, n); check_eq("rst_div", n, 4);

    // out-of-range select changes nothing
    write_div(3, 1);
    wait_rise(0, n);
    measure(0, 1'b1, n); check_eq("sel_oob", n, 4);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) en[$urandom_range(0, CH-1)] ^= 1'b1;
      if ($urandom_range(0, 59) == 0) mode[$urandom_range(0, CH-1)] ^= 1'b1;
      for (int c = 0; c < CH; c++) step[c] = ($urandom_range(0, 5) == 0);
      div_wr  = ($urandom_range(0, 7) == 0);
      div_sel = SW'($urandom_range(0, 3));
      div_val = CW'($urandom_range(0, 6));
      rst     = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0; div_wr = 1'b0; step = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock divider for the one-bit CPU and its peripherals: each channel derives a 50 %-duty slow clock and a one-cycle tick strobe from the single system clock. Unlike the fixed-rate divider it replaces, the divisor is runtime-programmable per channel, the active divisor is updated glitch-free, and each channel can run free or advance one slow-clock period per step request for single-stepping the CPU.

## Interface
- `CHANNELS`, 2, number of independent divider channels (1..8)
- `CNT_W`, 20, width of divisor and counter; must hold `DEFAULT_DIV`
- `DEFAULT_DIV`, 1_000_000, half-period in `clk` cycles loaded at reset into every channel
- `SEL_W`, `$clog2(CHANNELS)` (min 1), width of `div_sel`

- `clk`  in  1  system clock, all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  CHANNELS  per-channel enable
- `mode`  in  CHANNELS  per-channel mode: 0 free-run, 1 single-step
- `step`  in  CHANNELS  per-channel step request, one-cycle strobe, synchronous to `clk`
- `div_wr`  in  1  divisor write strobe
- `div_sel`  in  SEL_W  channel addressed by `div_wr`
- `div_val`  in  CNT_W  new half-period D
- `slow_clk`  out  CHANNELS  divided clocks, registered
- `tick`  out  CHANNELS  high for exactly the first cycle of each `slow_clk` high phase

## Operation
- Per channel: active divisor `div_q`, shadow divisor `div_s`, counter `cnt`, state.
- Reset: state STOP, `cnt`=0, `div_q`=`div_s`=DEFAULT_DIV, `slow_clk`=0, `tick`=0.
- Divisor write: `div_wr`=1 → `div_s[div_sel]` <= `div_val`; `div_val`=0 stored as 1; `div_sel` ≥ CHANNELS ignored.
- `div_q` <= `div_s` every cycle in STOP and at every phase boundary (cycle `cnt` wraps to 0); never mid-phase.
- States:
  - STOP: `slow_clk`=0, `cnt`=0. `en`&!`mode` → LO. `en`&`mode`&`step` → STEP_HI with `slow_clk`=1, `tick`=1.
  - LO: `cnt` increments; at `cnt`==`div_q`-1 → HI, `cnt`=0, `slow_clk`=1, `tick`=1. `!en` or `mode`=1 → STOP immediately (output already low, no runt).
  - HI: `cnt` increments; at terminal → `slow_clk`=0, `cnt`=0, next LO if `en`&!`mode`, else STOP. Disable/mode change during HI never shortens the high phase.
  - STEP_HI: at terminal → STOP, `slow_clk`=0. `step` during STEP_HI ignored (not queued); `en` dropping does not abort.
- Terminal compare uses `cnt` ≥ `div_q`-1 (defensive; `div_q` stable within a phase).
- `tick` is 0 in every cycle except the first high cycle.

## Timing
- Free-run period exactly 2·D cycles: D cycles low, D high. D=1 → toggles every cycle.
- `en` rising sampled in cycle t (STOP) → LO from t+1; first `slow_clk` rise at t+1+D.
- Step sampled at t → `slow_clk`=1, `tick`=1 at t+1; `slow_clk`=1 for t+1..t+D; low at t+D+1; new step accepted from t+D+1 (STOP).
- Divisor write at t: takes effect on the phase beginning after the next boundary (or at t+1 if channel in STOP).
- `rst` overrides all inputs, including mid-phase; outputs 0 the cycle after `rst` sampled.
- Channels fully independent; simultaneous `div_wr` to one channel and boundary on it: boundary loads the old `div_s`, new value applies at the following boundary.

## Structure
- Package `clk_div_pkg`: state encoding localparams (STOP, LO, HI, STEP_HI), divisor clamp function.
- Sub-module `clk_div_channel` (one channel: shadow/active divisor, counter, FSM, outputs); `clk_div_bank` generates CHANNELS instances and decodes `div_wr`/`div_sel` into per-channel write strobes.

## Test plan
- Reset, DEFAULT_DIV=4, ch0 `en`=1 free-run → first rise 5 cycles after `en`, then period 8, duty 4/4, one `tick` per rise.
- Write D=2 to ch0 mid-high-phase → current phase finishes at 4, next phases 2 cycles; ch1 unaffected; `div_val`=0 → period 2.
- ch1 `mode`=1, `step` pulse → exactly one high pulse of D cycles, `tick` once; second `step` during high ignored; step after return to STOP produces another.
- Drop `en` during HI → high phase completes at full length, then `slow_clk` stays 0; drop during LO → STOP next cycle, no pulse.
- Assert `rst` mid-high-phase with D=3 written → `slow_clk`=0, `tick`=0 next cycle, divisor back to 4.
- `div_sel`=CHANNELS with CHANNELS=3 → no divisor changes on any channel.
